// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shift/rotate engine with valid/ready request and response channels
// SHIFT_SEQ_STEP4_EN: move up to four bits per SHIFT edge instead of one.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vector,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stepped;

    // One-bit step of the latched operation; illegal codes never reach SHIFT.
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [2:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            OP_LSL:  r = {v[WIDTH-2:0], 1'b0};
            OP_LSR:  r = {1'b0, v[WIDTH-1:1]};
            OP_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stepped = work_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d = in_vector;
                    op_d   = in_op;
                    cnt_d  = in_amt;
                    if (in_op > OP_ROR) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (in_amt == '0) begin
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
`ifdef SHIFT_SEQ_STEP4_EN
                // Chain of four single-bit steps, each gated by the remaining count.
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(cnt_q)) begin
                        stepped = step1(stepped, op_q);
                    end
                end
                cnt_d = (int'(cnt_q) > 4) ? cnt_q - AMT_W'(4) : '0;
`else
                stepped = step1(work_q, op_q);
                cnt_d   = cnt_q - AMT_W'(1);
`endif
                work_d = stepped;
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = work_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - scoreboard bench for shift_seq with directed vectors
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_vector = '0;
    logic [2:0] in_op = '0;
    logic [2:0] in_amt = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
    logic       out_err;

    shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vector  (in_vector),
        .in_op      (in_op),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       err;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   seen_valid = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int lat_of(input logic [2:0] op, input logic [2:0] amt);
        if (op > 3'd4 || amt == 3'd0) return 0;
`ifdef SHIFT_SEQ_STEP4_EN
        return (int'(amt) + 3) / 4;
`else
        return int'(amt);
`endif
    endfunction

    // Monitor: compares every cycle the response is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("result", int'(out_result), int'(exp_q[0].res));
                chk("err", int'(out_err), int'(exp_q[0].err));
                chk("in_ready_in_done", int'(in_ready), 0);
                if (!seen_valid) begin
                    chk("latency", cyc, exp_q[0].due);
                    seen_valid = 1;
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen_valid = 0;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("wait_in_ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [7:0] v, input logic [2:0] op, input logic [2:0] amt,
                         input logic [7:0] er, input logic ee, output int e0);
        exp_t e;
        wait_ready();
        in_vector = v;
        in_op     = op;
        in_amt    = amt;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        e0       = cyc;
        in_valid = 1'b0;
        // Scramble inputs mid-operation; the engine must ignore them.
        in_vector = ~v;
        in_op     = 3'd7;
        in_amt    = 3'd0;
        e.res = er;
        e.err = ee;
        e.due = e0 + lat_of(op, amt);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
    endtask

    typedef struct {
        logic [7:0] v;
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] r;
        logic       e;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int   e0, e1;

        vecs.push_back('{8'hEB, 3'd0, 3'd1, 8'hD6, 1'b0});
        vecs.push_back('{8'hEB, 3'd1, 3'd3, 8'h1D, 1'b0});
        vecs.push_back('{8'hEB, 3'd2, 3'd3, 8'hFD, 1'b0});
        vecs.push_back('{8'hEB, 3'd3, 3'd1, 8'hD7, 1'b0});
        vecs.push_back('{8'hEB, 3'd4, 3'd1, 8'hF5, 1'b0});
        for (int i = 0; i < 5; i++) vecs.push_back('{8'hEB, 3'(i), 3'd0, 8'hEB, 1'b0});
        vecs.push_back('{8'h81, 3'd2, 3'd7, 8'hFF, 1'b0});
        vecs.push_back('{8'h81, 3'd1, 3'd7, 8'h01, 1'b0});
        vecs.push_back('{8'h81, 3'd3, 3'd4, 8'h18, 1'b0});
        vecs.push_back('{8'h81, 3'd4, 3'd5, 8'h0C, 1'b0});
        vecs.push_back('{8'h5A, 3'd6, 3'd3, 8'h5A, 1'b1});

        #1;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_result", int'(out_result), 0);
        chk("reset_out_err", int'(out_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].v, vecs[i].op, vecs[i].amt, vecs[i].r, vecs[i].e, e0);
        end
        drain();

        // Back-to-back turnaround with out_ready held high.
        issue(8'hEB, 3'd1, 3'd3, 8'h1D, 1'b0, e0);
        issue(8'hEB, 3'd3, 3'd1, 8'hD7, 1'b0, e1);
        chk("turnaround", e1 - e0, lat_of(3'd1, 3'd3) + 2);
        drain();

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(8'hFF, 3'd4, 3'd7, 8'hFF, 1'b0, e0);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("hold_reached_done", int'(out_valid), 1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_after_release", int'(in_ready), 1);
        chk("out_result_kept", int'(out_result), 8'hFF);
        issue(8'h3C, 3'd5, 3'd2, 8'h3C, 1'b1, e0);
        drain();

        // Reset mid-SHIFT aborts the operation.
        wait_ready();
        in_vector = 8'hEB;
        in_op     = 3'd0;
        in_amt    = 3'd5;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_in_shift", int'(in_ready), 0);
        @(posedge clk);
`ifndef SHIFT_SEQ_STEP4_EN
        @(posedge clk);
`endif
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_result", int'(out_result), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_err", int'(out_err), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_no_valid", int'(out_valid), 0);

        issue(8'hEB, 3'd0, 3'd7, 8'h80, 1'b0, e0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
